// File: rtl/u110_bus_arbiter.sv
// U110 68040 local-bus arbiter: CPU parked owner, round-robin PCI requesters.
// Optional grant timeout is built when U110_ARB_TIMEOUT_EN is defined.
module u110_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK40,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQn,
  input  logic               BBn,
  output logic               BGn,
  output logic [NUM_REQ-1:0] GNTn,
  output logic               PCI_OWNER,
  output logic               ARB_TO
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    CPU_OWN,
    CPU_REL,
    GRANT,
    MASTER_OWN,
    MASTER_REL
  } state_t;

  state_t             state_q;
  logic [IDXW-1:0]    w_q;
  logic [IDXW-1:0]    last_q;
  logic               bgn_q;
  logic [NUM_REQ-1:0] gntn_q;
  logic               pci_q;
  logic               to_q;

  logic [IDXW-1:0]    sel;
  logic               sel_valid;
  logic [NUM_REQ-1:0] sel_gntn;
  logic               timeout_hit;
  int                 scan_idx;
  logic [IDXW-1:0]    scan_pos;

  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
    $error("u110_bus_arbiter: NUM_REQ or TIMEOUT out of range");
  end

  // Scan farthest-first so the nearest requester after last_q is the final assignment.
  always_comb begin
    sel       = last_q;
    sel_valid = 1'b0;
    scan_idx  = 0;
    scan_pos  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = int'(last_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_pos = IDXW'(scan_idx);
      if (!REQn[scan_pos]) begin
        sel       = scan_pos;
        sel_valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign sel_gntn[gi] = (sel != IDXW'(gi));
  end

`ifdef U110_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;

  // Held at zero outside GRANT, so every grant starts counting from zero.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (state_q != GRANT) begin
      cnt_q <= '0;
    end else if (BBn && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout_hit = BBn && (cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q <= CPU_OWN;
      w_q     <= '0;
      last_q  <= IDXW'(NUM_REQ - 1);
      bgn_q   <= 1'b0;
      gntn_q  <= '1;
      pci_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        CPU_OWN: begin
          if (!(&REQn)) begin
            state_q <= CPU_REL;
            bgn_q   <= 1'b1;
          end
        end
        CPU_REL: begin
          if (BBn) begin
            if (sel_valid) begin
              state_q <= GRANT;
              w_q     <= sel;
              last_q  <= sel;
              gntn_q  <= sel_gntn;
              pci_q   <= 1'b1;
            end else begin
              state_q <= CPU_OWN;
              bgn_q   <= 1'b0;
            end
          end
        end
        GRANT: begin
          // A withdrawn request beats the bus being taken in the same cycle.
          if (REQn[w_q]) begin
            state_q <= MASTER_REL;
            gntn_q  <= '1;
          end else if (!BBn) begin
            state_q <= MASTER_OWN;
          end else if (timeout_hit) begin
            state_q <= MASTER_REL;
            gntn_q  <= '1;
            to_q    <= 1'b1;
          end
        end
        MASTER_OWN: begin
          if (REQn[w_q]) begin
            state_q <= MASTER_REL;
            gntn_q  <= '1;
          end
        end
        MASTER_REL: begin
          if (BBn) begin
            if (sel_valid) begin
              state_q <= GRANT;
              w_q     <= sel;
              last_q  <= sel;
              gntn_q  <= sel_gntn;
            end else begin
              state_q <= CPU_OWN;
              bgn_q   <= 1'b0;
              pci_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= CPU_OWN;
          bgn_q   <= 1'b0;
          gntn_q  <= '1;
          pci_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BGn       = bgn_q;
  assign GNTn      = gntn_q;
  assign PCI_OWNER = pci_q;
  assign ARB_TO    = to_q;
endmodule

// File: tb/tb_u110_bus_arbiter.sv
// Directed bench for u110_bus_arbiter (NUM_REQ=4, TIMEOUT=16); timeout
// checks follow U110_ARB_TIMEOUT_EN.
module tb_u110_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] reqn;
  logic       bbn;
  logic       bgn;
  logic [3:0] gntn;
  logic       pci_owner;
  logic       arb_to;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_gntn = 4'b1111;
  logic [3:0] cur;
  logic [3:0] rr_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  always #5 clk = ~clk;

  u110_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .CLK40    (clk),
    .RESET    (rst),
    .REQn     (reqn),
    .BBn      (bbn),
    .BGn      (bgn),
    .GNTn     (gntn),
    .PCI_OWNER(pci_owner),
    .ARB_TO   (arb_to)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mutual exclusion and an all-high gap between different grant owners.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mutex", 32'($countones({~bgn, ~gntn}) <= 1), 32'd1);
      if (prev_gntn != 4'b1111 && gntn != 4'b1111) chk("handoff", 32'(gntn), 32'(prev_gntn));
      prev_gntn = gntn;
    end
  end

  initial begin
    rst  = 1'b1;
    reqn = 4'b0000;
    bbn  = 1'b1;
    tick(3);
    mon_en = 1'b1;
    chk("rst_bgn", 32'(bgn), 32'd0);
    chk("rst_gntn", 32'(gntn), 32'hF);
    chk("rst_pci", 32'(pci_owner), 32'd0);
    chk("rst_to", 32'(arb_to), 32'd0);

    rst = 1'b0;
    tick();
    chk("rel_bgn", 32'(bgn), 32'd1);
    chk("rel_gntn", 32'(gntn), 32'hF);
    tick();
    chk("first_gnt", 32'(gntn), 32'hE);
    chk("first_pci", 32'(pci_owner), 32'd1);

    // Round-robin 0 -> 1 -> 2 -> 3 -> 0 with every requester asking.
    cur = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      bbn = 1'b0;
      tick();
      chk("rr_own", 32'(gntn), 32'(cur));
      reqn = ~cur;
      tick();
      chk("rr_rel", 32'(gntn), 32'hF);
      bbn  = 1'b1;
      reqn = 4'b0000;
      tick();
      chk("rr_next", 32'(gntn), 32'(rr_exp[k]));
      cur = rr_exp[k];
    end

    // Requester 0 withdraws before taking the bus; nobody else asks.
    reqn = 4'b1111;
    tick();
    chk("back_gntn", 32'(gntn), 32'hF);
    chk("back_pci", 32'(pci_owner), 32'd1);
    chk("back_bgn", 32'(bgn), 32'd1);
    tick();
    chk("cpu_bgn", 32'(bgn), 32'd0);
    chk("cpu_pci", 32'(pci_owner), 32'd0);

    // Single requester 2.
    reqn = 4'b1011;
    tick();
    chk("single_bgn", 32'(bgn), 32'd1);
    tick();
    chk("single_gnt", 32'(gntn), 32'hB);
    bbn = 1'b0;
    tick();
    chk("single_own", 32'(gntn), 32'hB);
    reqn = 4'b1111;
    tick();
    chk("single_rel", 32'(gntn), 32'hF);
    bbn = 1'b1;
    tick();
    chk("single_bgn0", 32'(bgn), 32'd0);

    // CPU keeps the bus busy for 10 cycles while requester 1 waits.
    reqn = 4'b1101;
    bbn  = 1'b0;
    tick();
    chk("hold_bgn", 32'(bgn), 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hold_nognt", 32'(gntn), 32'hF);
    end
    bbn = 1'b1;
    tick();
    chk("hold_gnt", 32'(gntn), 32'hD);

    // Requester 1 withdraws while 3 is pending.
    reqn = 4'b0101;
    tick();
    chk("wd_still", 32'(gntn), 32'hD);
    reqn = 4'b0111;
    tick();
    chk("wd_neg", 32'(gntn), 32'hF);
    tick();
    chk("wd_gnt3", 32'(gntn), 32'h7);
    reqn = 4'b1111;
    tick();
    chk("wd_rel3", 32'(gntn), 32'hF);
    tick();
    chk("wd_cpu", 32'(bgn), 32'd0);

    // Requester 0 granted and never takes the bus; requester 1 pending.
    reqn = 4'b1100;
    tick();
    chk("to_bgn", 32'(bgn), 32'd1);
    tick();
    chk("to_gnt0", 32'(gntn), 32'hE);
`ifdef U110_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_wait_gnt", 32'(gntn), 32'hE);
      chk("to_wait_pulse", 32'(arb_to), 32'd0);
    end
    tick();
    chk("to_expire_gnt", 32'(gntn), 32'hF);
    chk("to_expire_pulse", 32'(arb_to), 32'd1);
    chk("to_expire_pci", 32'(pci_owner), 32'd1);
    tick();
    chk("to_next_gnt", 32'(gntn), 32'hD);
    chk("to_pulse_end", 32'(arb_to), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noto_gnt", 32'(gntn), 32'hE);
      chk("noto_pulse", 32'(arb_to), 32'd0);
    end
    reqn = 4'b1101;
    tick();
    chk("noto_rel", 32'(gntn), 32'hF);
    tick();
    chk("noto_next", 32'(gntn), 32'hD);
`endif

    // Reset while a grant is live; round-robin pointer must restart.
    rst  = 1'b1;
    reqn = 4'b0101;
    tick();
    chk("mid_rst_gntn", 32'(gntn), 32'hF);
    chk("mid_rst_bgn", 32'(bgn), 32'd0);
    chk("mid_rst_pci", 32'(pci_owner), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rel_bgn", 32'(bgn), 32'd1);
    tick();
    chk("mid_gnt1", 32'(gntn), 32'hD);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/u110_bus_arbiter.md
# u110_bus_arbiter

Arbitrates ownership of the 68040 local bus between the CPU and up to `NUM_REQ` PCI-side bus masters. It replaces the tied-off arbiter in the U110 FPGA and drives the CPU bus grant and one grant line per PCI requester. The CPU is the default (parked) owner. PCI requesters are served round-robin. An optional grant timeout reclaims the bus from a master that is granted but never takes the bus.

## Interface
Parameters:
- `NUM_REQ`, 4: number of PCI-side requesters (1–8).
- `TIMEOUT`, 16: CLK40 cycles a grant may stand unused before withdrawal (2–255).

Ports:
- `CLK40`, in, 1: 40 MHz PLL clock; the only clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `REQn`, in, `NUM_REQ`: bus requests, active low, bit i = requester i; synchronous to CLK40.
- `BBn`, in, 1: bus busy, active low; driven by the current owner.
- `BGn`, out, 1: CPU bus grant, active low.
- `GNTn`, out, `NUM_REQ`: PCI requester grants, active low, one-hot-or-none.
- `PCI_OWNER`, out, 1: high while a PCI requester is granted or owns the bus. Drives bus direction.
- `ARB_TO`, out, 1: one-cycle pulse when a grant times out.

## Operation
- States: CPU_OWN, CPU_REL, GRANT, MASTER_OWN, MASTER_REL. The winner index `w` is registered, and the round-robin pointer `last` holds the index of the most recently granted requester.
- **CPU_OWN:** `BGn`=0 and all `GNTn`=1. If any `REQn` is low, go to CPU_REL.
- **CPU_REL:** `BGn`=1. Wait for `BBn`=1.
  - If requests are pending, pick `w` and go to GRANT.
  - If no requests are pending, return to CPU_OWN.
- **Winner selection:** the first requester with `REQn` low, scanning from index `last`+1 upward and wrapping modulo `NUM_REQ`. `last` is updated to `w` when the grant is issued.
- **GRANT:** `GNTn[w]`=0.
  - `BBn`=0 → MASTER_OWN.
  - `REQn[w]`=1 before the bus is taken → negate the grant and go to MASTER_REL.
- **MASTER_OWN:** `GNTn[w]` is held low while `REQn[w]`=0. When `REQn[w]`=1, negate the grant and go to MASTER_REL.
- **MASTER_REL:** all grants are high. Wait for `BBn`=1.
  - If other requests are pending, select the next winner and go to GRANT.
  - Otherwise, go to CPU_OWN with `BGn`=0.
- **Mutual exclusion:** at most one of `BGn` and `GNTn[*]` is asserted in any cycle. Grants never overlap. There is at least one cycle with all grants negated between owners.
- **`PCI_OWNER`:** 1 in GRANT, MASTER_OWN and MASTER_REL; 0 otherwise.
- **Reset values:** state=CPU_OWN, `BGn`=0, `GNTn`=all 1, `PCI_OWNER`=0, `ARB_TO`=0, `last`=`NUM_REQ`-1 (so index 0 wins first), timeout counter=0.
- **Reset mid-operation:** on any cycle with `RESET`=1, all registers load their reset values at that edge. A grant in flight is dropped immediately.
- **Invalid indices:** requests from indices ≥ `NUM_REQ` do not exist, and the scan never produces them.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `REQn` low sampled at edge n (state CPU_OWN) → `BGn`=1 after edge n.
- `BBn`=1 sampled at edge m (state CPU_REL) → `GNTn[w]`=0 after edge m.
  - Minimum request-to-grant latency is 2 cycles when the bus is idle.
- `REQn[w]` high sampled at edge k → `GNTn[w]`=1 after edge k.
- The next grant follows at the earliest edge after `BBn`=1 is sampled in MASTER_REL. There is at least 1 idle-grant cycle.
- **Simultaneous events:**
  - A new request arriving in the same cycle as the owner's release is considered in that edge's selection.
  - `REQn[w]` rising in the same cycle as `BBn` falling in GRANT: the release wins, and the state goes to MASTER_REL.
- The timeout counter is 8 bits wide. It saturates and never wraps.

## Configuration
- `U110_ARB_TIMEOUT_EN` defined:
  - In GRANT, the counter increments each cycle while `BBn`=1. It clears on entry to GRANT.
  - When the count reaches `TIMEOUT`, negate `GNTn[w]`, pulse `ARB_TO` for 1 cycle, and go to MASTER_REL. `last` stays at `w`, so that requester is skipped next round.
- `U110_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `ARB_TO` is tied to 0.
  - GRANT waits indefinitely for `BBn`=0 or `REQn[w]`=1.

## Test plan
- **Reset:** hold `RESET`=1 for 3 cycles with `REQn`=4'b0000 → `BGn`=0, `GNTn`=4'b1111, `PCI_OWNER`=0. Release reset with `BBn`=1 → `BGn`=1 after 1 cycle, then `GNTn`=4'b1110 after the next cycle.
- **Single requester:** `REQn`=4'b1011, `BBn`=1 → `BGn` high, then `GNTn`=4'b1011. Drive `BBn`=0, then raise `REQn[2]` → `GNTn`=4'b1111. Raise `BBn` → `BGn`=0 one cycle later.
- **Round-robin:** hold `REQn`=4'b0000 and have each owner take the bus and release it → grant order is 0,1,2,3,0. No two grants are ever low together, and there is at least one all-high cycle between each pair.
- **CPU holds bus:** request while `BBn`=0 for 10 cycles → no grant asserted until 1 cycle after `BBn` returns to 1.
- **Withdrawal:** requester 1 is granted, then raises `REQn[1]` before `BBn` falls → grant is negated next edge. Requester 3 is pending and is granted after MASTER_REL.
- **Timeout (`U110_ARB_TIMEOUT_EN`, `TIMEOUT`=16):** requester 0 is granted and `BBn` stays 1 → `GNTn[0]` rises after 16 cycles and `ARB_TO` pulses once. Pending requester 1 is granted next.
